bram_tdp: RTL and testbench

BRAM_TDP -- requirements
Module: bram_tdp

---
 rtl/bram_tdp.sv | 34 +++
 tb/tb_bram_tdp.sv | 104 ++++++++++
 2 files changed

// File: rtl/bram_tdp.sv
// bram_tdp: true dual-port block RAM, one clock, write-first per port, port A wins same-address write collisions.
module bram_tdp #(
  parameter int DW = 8,
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enA,
  input  logic          weA,
  input  logic [AW-1:0] addrA,
  input  logic [DW-1:0] dinA,
  output logic [DW-1:0] doutA,
  input  logic          enB,
  input  logic          weB,
  input  logic [AW-1:0] addrB,
  input  logic [DW-1:0] dinB,
  output logic [DW-1:0] doutB
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          wr_a, wr_b;
  assign wr_a = rst_n && enA && weA;
  assign wr_b = rst_n && enB && weB;
  // A's write is issued last so it is the one stored on an address collision
  always_ff @(posedge clk) begin
    if (wr_b) mem[addrB] <= dinB;
    if (wr_a) mem[addrA] <= dinA;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) doutA <= '0;
    else if (enA) doutA <= weA ? dinA : mem[addrA];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) doutB <= '0;
    else if (enB) doutB <= weB ? dinB : mem[addrB];
endmodule

// File: tb/tb_bram_tdp.sv
// tb_bram_tdp: randomized and directed checks of bram_tdp against an associative-array memory model.
module tb_bram_tdp;
  logic        clk = 0, rst_n;
  logic        enA, weA, enB, weB;
  logic [16:0] addrA, addrB;
  logic [7:0]  dinA, dinB, doutA, doutB;
  logic [7:0]  mdl [logic [16:0]];
  logic [7:0]  exp_a, exp_b;
  logic [16:0] pool [8];
  int          checks = 0, failures = 0;

  bram_tdp #(.DW(8), .AW(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input string tag,
                      input logic ea, input logic wa, input logic [16:0] aa, input logic [7:0] da,
                      input logic eb, input logic wb, input logic [16:0] ab, input logic [7:0] db);
    enA = ea; weA = wa; addrA = aa; dinA = da;
    enB = eb; weB = wb; addrB = ab; dinB = db;
    @(posedge clk);
    if (rst_n) begin
      if (ea) exp_a = wa ? da : mdl[aa];
      if (eb) exp_b = wb ? db : mdl[ab];
      if (eb && wb) mdl[ab] = db;
      if (ea && wa) mdl[aa] = da;
    end
    @(negedge clk);
    check({tag, "_a"}, doutA, exp_a);
    check({tag, "_b"}, doutB, exp_b);
  endtask

  initial begin
    rst_n = 0;
    enA = 0; weA = 0; addrA = '0; dinA = '0;
    enB = 0; weB = 0; addrB = '0; dinB = '0;
    exp_a = '0; exp_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", doutA, 8'h00);
    check("reset_b", doutB, 8'h00);
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      step("pp0", 1, 1, 17'h0A5A5, 8'hDD, 1, 1, 17'h05858, 8'hA6);
      step("pp1", 1, 1, 17'h15A5A, 8'hA6, 1, 1, 17'h1A7A7, 8'hDD);
    end

    step("wr10", 1, 1, 17'h00010, 8'h3C, 0, 0, 17'h0, 8'h0);
    step("rd10", 0, 0, 17'h0, 8'h0, 1, 0, 17'h00010, 8'h0);
    check("rd10_lit", doutB, 8'h3C);

    step("dis_a", 0, 1, 17'h00010, 8'hF0, 0, 0, 17'h0, 8'h0);
    check("dis_a_lit", doutA, 8'h3C);
    step("dis_rd", 0, 0, 17'h0, 8'h0, 1, 0, 17'h00010, 8'h0);
    check("dis_rd_lit", doutB, 8'h3C);

    step("pre20", 1, 1, 17'h00020, 8'h11, 0, 0, 17'h0, 8'h0);
    step("rw20", 1, 1, 17'h00020, 8'h55, 1, 0, 17'h00020, 8'h0);
    check("rw20_lit", doutB, 8'h11);
    step("rd20", 0, 0, 17'h0, 8'h0, 1, 0, 17'h00020, 8'h0);
    check("rd20_lit", doutB, 8'h55);

    step("ww", 1, 1, 17'h0AAAA, 8'h01, 1, 1, 17'h0AAAA, 8'h02);
    check("ww_lit_a", doutA, 8'h01);
    check("ww_lit_b", doutB, 8'h02);
    step("ww_rd", 1, 0, 17'h0AAAA, 8'h0, 1, 0, 17'h0AAAA, 8'h0);
    check("ww_rd_lit", doutA, 8'h01);

    for (int i = 0; i < 8; i++) begin
      pool[i] = 17'($urandom);
      step("init", 1, 1, pool[i], 8'($urandom), 0, 0, 17'h0, 8'h0);
    end
    for (int i = 0; i < 300; i++)
      step("rnd", 1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
                  1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));

    #2 rst_n = 0;
    #1;
    exp_a = '0; exp_b = '0;
    check("async_rst_a", doutA, 8'h00);
    check("async_rst_b", doutB, 8'h00);
    @(negedge clk);
    step("rst_wr", 1, 1, pool[0], ~mdl[pool[0]], 1, 1, pool[1], ~mdl[pool[1]]);
    rst_n = 1;
    for (int i = 0; i < 8; i++)
      step("post_rst", 1, 0, pool[i], 8'h0, 1, 0, pool[7 - i], 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
